pipo_register: RTL and testbench
================================

// Module: pipo_register
// PURPOSE
//   Parallel-in/parallel-out register. Captures a WIDTH-bit word on every
//   rising clock edge and presents it on the output after DEPTH cycles.
//   Used as a pipeline/retiming stage between datapath blocks; holds no
//   shift path, so all bits load simultaneously.
// PARAMETERS
//   WIDTH        4     data word width in bits (>=1)
//   DEPTH        1     number of register stages = latency in cycles (>=1)
//   RESET_VALUE  0     value loaded into every stage on reset (WIDTH bits)
// PORTS
//   clk   in   1      rising-edge clock; only clock in the block
//   rst   in   1      synchronous, active-high reset
//   in    in   WIDTH  parallel data input
//   out   out  WIDTH  parallel data output = last stage
//   en    in   1      stage enable; present only with PIPO_HOLD_EN
// BEHAVIOUR
//   - One clock (clk); reset (rst) is synchronous and active-high.
//   - Internal stages s[0..DEPTH-1]; out driven combinationally from s[DEPTH-1],
//     no logic between the register and the port.
//   - At posedge clk with rst=1: every s[k] <= RESET_VALUE; input ignored.
//   - At posedge clk with rst=0: s[0] <= in; s[k] <= s[k-1] for k>=1.
//   - Latency: a word on in at edge N appears on out just after edge N+DEPTH-1
//     (DEPTH=1: visible after the same edge that captured it).
//   - Reset value of out: RESET_VALUE (default 4'b0000) after the first edge with
//     rst=1; out is undefined before the first reset edge.
//   - rst asserted mid-stream: all in-flight words discarded at that edge; after
//     release the pipeline refills, out shows RESET_VALUE until new data
//     reaches stage DEPTH-1.
//   - rst changing between edges has no effect until the next edge.
//   - Repeated identical inputs: out holds steady, no glitch, no toggle.
//   - No arithmetic; bit i of in maps to bit i of out, no reordering.
//   - DEPTH<1 or WIDTH<1: elaboration error (generate-time check).
// CONFIGURATION
//   PIPO_HOLD_EN defined: port en added. At posedge with rst=0 and en=0 all
//     stages hold their value; en=1 behaves as the base design. rst has
//     priority over en (reset loads RESET_VALUE regardless of en).
//   PIPO_HOLD_EN undefined: no en port; stages load on every edge.
// TESTING (WIDTH=4, DEPTH=1, RESET_VALUE=0, 10-unit clock period)
//   1. rst=1 for 4 edges, in=0011,1010,1111,1011 -> out=0000 after each edge.
//   2. rst=0, in=0001 -> out=0001 after next edge; then in=1101,1100,1001 ->
//      out follows one word per edge.
//   3. in=1001 on two consecutive edges -> out stays 1001, no change.
//   4. Mid-stream: out=1100, rst=1 for one edge -> out=0000; release, in=0110
//      -> out=0110 on following edge.
//   5. DEPTH=3: in=1010 at edge N, 0101 at N+1 -> out=1010 after edge N+2,
//      0101 after N+3; out=0000 until then after reset.
//   6. PIPO_HOLD_EN: out=0011, en=0, in=1111 for 3 edges -> out stays 0011;
//      en=0 with rst=1 -> out=0000; en=1 -> out=1111 after next edge.

Source files
------------

// File: rtl/pipo_register.sv
// Parallel-in/parallel-out register: DEPTH stages of WIDTH bits, out taps the last stage.
// Optional PIPO_HOLD_EN adds an 'en' port that freezes every stage while low.
module pipo_register #(
    parameter int unsigned            WIDTH       = 4,
    parameter int unsigned            DEPTH       = 1,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PIPO_HOLD_EN
    input  logic             en,
`endif
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    generate
        if (DEPTH < 1 || WIDTH < 1) begin : g_bad_params
            $error("pipo_register: WIDTH and DEPTH must both be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] stage [DEPTH];
    logic             load;

`ifdef PIPO_HOLD_EN
    assign load = en;
`else
    assign load = 1'b1;
`endif

    // Reset wins over the enable so a held pipeline can still be cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stage[k] <= RESET_VALUE;
            end
        end else if (load) begin
            stage[0] <= in;
            for (int k = 1; k < int'(DEPTH); k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign out = stage[DEPTH-1];

endmodule

// File: tb/tb_pipo_register.sv
// Self-checking bench for pipo_register: a DEPTH=1 and a DEPTH=3 instance checked
// against a queue-based model of the pipeline contents.
module tb_pipo_register;

    localparam int          D1  = 1;
    localparam int          D3  = 3;
    localparam logic [7:0]  RV3 = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b1;
    logic [3:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [3:0] out_a;
    logic [7:0] out_b;

    int passes = 0;
    int total  = 0;

    logic [3:0] q1 [$];
    logic [7:0] q3 [$];

    always #5 clk = ~clk;

    pipo_register #(.WIDTH(4), .DEPTH(D1), .RESET_VALUE(4'b0000)) dut_a (
        .clk (clk),
        .rst (rst),
`ifdef PIPO_HOLD_EN
        .en  (en),
`endif
        .in  (in_a),
        .out (out_a)
    );

    pipo_register #(.WIDTH(8), .DEPTH(D3), .RESET_VALUE(RV3)) dut_b (
        .clk (clk),
        .rst (rst),
`ifdef PIPO_HOLD_EN
        .en  (en),
`endif
        .in  (in_b),
        .out (out_b)
    );

    // Drive on the falling edge, advance the model at the rising edge, sample 1 unit later.
    task automatic applyStimulus(input logic r, input logic [3:0] a, input logic [7:0] b, input logic e);
        logic hold;
        @(negedge clk);
        rst  = r;
        in_a = a;
        in_b = b;
        en   = e;
        @(posedge clk);
`ifdef PIPO_HOLD_EN
        hold = !e;
`else
        hold = 1'b0;
`endif
        if (r) begin
            q1.delete();
            q3.delete();
            for (int k = 0; k < D1; k++) q1.push_back(4'b0000);
            for (int k = 0; k < D3; k++) q3.push_back(RV3);
        end else if (!hold) begin
            q1.push_back(a);
            void'(q1.pop_front());
            q3.push_back(b);
            void'(q3.pop_front());
        end
        #1;
    endtask

    task automatic checkOutput(input string tag);
        total++;
        assert (out_a === q1[0]) passes++;
        else $error("[TB] FAIL %s d1: out=%b expected=%b", tag, out_a, q1[0]);
        total++;
        assert (out_b === q3[0]) passes++;
        else $error("[TB] FAIL %s d3: out=%h expected=%h", tag, out_b, q3[0]);
    endtask

    initial begin
        logic [3:0] ra;
        logic [7:0] rb;
        logic       rr;
        logic       re;

        // Reset held for four edges while inputs change
        applyStimulus(1'b1, 4'b0011, 8'h11, 1'b1); checkOutput("reset0");
        applyStimulus(1'b1, 4'b1010, 8'h22, 1'b1); checkOutput("reset1");
        applyStimulus(1'b1, 4'b1111, 8'h33, 1'b1); checkOutput("reset2");
        applyStimulus(1'b1, 4'b1011, 8'h44, 1'b1); checkOutput("reset3");

        // Stream, including pipeline fill on the deep instance
        applyStimulus(1'b0, 4'b0001, 8'h3C, 1'b1); checkOutput("stream0");
        applyStimulus(1'b0, 4'b1101, 8'hC3, 1'b1); checkOutput("stream1");
        applyStimulus(1'b0, 4'b1100, 8'h81, 1'b1); checkOutput("stream2");
        applyStimulus(1'b0, 4'b1001, 8'h7E, 1'b1); checkOutput("stream3");

        // Repeated word holds steady
        applyStimulus(1'b0, 4'b1001, 8'h7E, 1'b1); checkOutput("repeat0");
        applyStimulus(1'b0, 4'b1001, 8'h7E, 1'b1); checkOutput("repeat1");

        // Mid-stream reset flushes in-flight words
        applyStimulus(1'b0, 4'b1100, 8'h5A, 1'b1); checkOutput("mid_pre");
        applyStimulus(1'b1, 4'b1111, 8'hFF, 1'b1); checkOutput("mid_rst");
        applyStimulus(1'b0, 4'b0110, 8'h10, 1'b1); checkOutput("mid_rel0");
        applyStimulus(1'b0, 4'b0111, 8'h20, 1'b1); checkOutput("mid_rel1");
        applyStimulus(1'b0, 4'b1000, 8'h30, 1'b1); checkOutput("mid_rel2");

`ifdef PIPO_HOLD_EN
        // Enable low freezes all stages; reset still clears them
        applyStimulus(1'b0, 4'b0011, 8'h33, 1'b1); checkOutput("hold_load");
        applyStimulus(1'b0, 4'b1111, 8'hEE, 1'b0); checkOutput("hold0");
        applyStimulus(1'b0, 4'b1111, 8'hEE, 1'b0); checkOutput("hold1");
        applyStimulus(1'b0, 4'b1111, 8'hEE, 1'b0); checkOutput("hold2");
        applyStimulus(1'b1, 4'b1111, 8'hEE, 1'b0); checkOutput("hold_rst");
        applyStimulus(1'b0, 4'b1111, 8'hEE, 1'b1); checkOutput("hold_en");
`endif

        // Randomized traffic with occasional resets and enable drops
        for (int i = 0; i < 300; i++) begin
            ra = 4'($urandom);
            rb = 8'($urandom);
            rr = ($urandom_range(0, 15) == 0);
            re = ($urandom_range(0, 3) != 0);
            applyStimulus(rr, ra, rb, re);
            checkOutput("random");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
